light_stand_ctrl: RTL

//  Consumes the one-cycle release pulse from the debounced push button and steps a lamp

---
 rtl/light_stand_pkg.sv | 36 +++
 rtl/pwm_gen.sv | 35 +++
 rtl/light_stand_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/light_stand_pkg.sv
// Shared types and constants for the light stand controller.
package light_stand_pkg;

  localparam int unsigned LEVEL_MAX = 4;
  localparam int unsigned LEVEL_W   = 3;
  localparam int unsigned TIMER_W   = 32;

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_L1  = 3'd1,
    S_L2  = 3'd2,
    S_L3  = 3'd3,
    S_L4  = 3'd4
  } state_t;

  function automatic state_t step_state(input state_t s);
    case (s)
      S_OFF:   return S_L1;
      S_L1:    return S_L2;
      S_L2:    return S_L3;
      S_L3:    return S_L4;
      default: return S_OFF;
    endcase
  endfunction

  function automatic logic [LEVEL_W-1:0] state_level(input state_t s);
    case (s)
      S_L1:    return LEVEL_W'(1);
      S_L2:    return LEVEL_W'(2);
      S_L3:    return LEVEL_W'(3);
      S_L4:    return LEVEL_W'(4);
      default: return LEVEL_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM with a duty that only changes on period boundaries,
// except for an immediate force-off.
module pwm_gen #(
  parameter int unsigned PERIOD = 100,
  parameter int unsigned DUTY_W = $clog2(PERIOD + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic              i_force_off,
  output logic              o_pwm
);

  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);

  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] duty_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt    <= '0;
      duty_q <= '0;
      o_pwm  <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + DUTY_W'(1);
      if (i_force_off) begin
        duty_q <= '0;
      end else if (cnt == LAST) begin
        duty_q <= i_duty;
      end
      o_pwm <= !i_force_off && (cnt < duty_q);
    end
  end

endmodule

// File: rtl/light_stand_ctrl.sv
// Push-button lamp stepper: OFF -> L1..L4 -> OFF, PWM brightness, idle auto-off.
module light_stand_ctrl
  import light_stand_pkg::*;
#(
  parameter int unsigned PWM_PERIOD      = 100,
  parameter int unsigned AUTO_OFF_CYCLES = 3_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_btn,
  output logic               o_pwm,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_on
);

  localparam int unsigned DUTY_W = $clog2(PWM_PERIOD + 1);
  localparam bit          AUTO_OFF_EN = (AUTO_OFF_CYCLES != 0);
  localparam logic [TIMER_W-1:0] EXPIRE_AT = TIMER_W'(AUTO_OFF_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_next;
  logic                 expire_c;
  logic [LEVEL_W-1:0]   level_next;
  logic                 force_off_c;
  logic [TIMER_W-1:0]   duty_full;
  logic [DUTY_W-1:0]    duty_c;

  assign expire_c = AUTO_OFF_EN && (state != S_OFF) && (timer == EXPIRE_AT);

  // State, idle timer and registered level outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_OFF;
      timer   <= '0;
      o_level <= '0;
      o_on    <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      o_level <= level_next;
      o_on    <= (level_next != '0);
    end
  end

  // Button advance beats expiry; timer only runs while lit.
  always_comb begin
    state_next = state;
    timer_next = timer + TIMER_W'(1);
    if (i_btn) begin
      state_next = step_state(state);
      timer_next = '0;
    end else if (expire_c) begin
      state_next = S_OFF;
      timer_next = '0;
    end
    if (state == S_OFF) begin
      timer_next = '0;
    end
  end

  // Level for the next cycle and PWM duty target from the current level.
  always_comb begin
    level_next  = state_level(state_next);
    force_off_c = (state_next == S_OFF);
    duty_full   = (TIMER_W'(PWM_PERIOD) * TIMER_W'(o_level)) / TIMER_W'(LEVEL_MAX);
    duty_c      = DUTY_W'(duty_full);
  end

  pwm_gen #(
    .PERIOD (PWM_PERIOD),
    .DUTY_W (DUTY_W)
  ) u_pwm (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_duty      (duty_c),
    .i_force_off (force_off_c),
    .o_pwm       (o_pwm)
  );

endmodule
